// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, handshake levels
// and the ALU opcodes the EX decoder uses to select DIV/DIVU.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (one quotient bit per clock) for the EX stage.
// Returns {remainder, quotient}; supports signed/unsigned mode, stall and annul.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 stall_o
);

    div_state_e           state_reg,  state_next;
    logic [CNT_W-1:0]     cnt_reg,    cnt_next;
    logic [WIDTH-1:0]     dvd_reg,    dvd_next;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     dvs_reg,    dvs_next;
    logic [WIDTH-1:0]     rem_reg,    rem_next;
    logic                 neg_q_reg,  neg_q_next;
    logic                 neg_r_reg,  neg_r_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic                 ready_reg,  ready_next;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_abs, op2_abs;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       trial_diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     quo_final, rem_final;

    // Absolute values wrap at WIDTH bits, so abs(min) stays min read unsigned.
    assign op1_neg = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_i & opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

    assign rem_shift  = {rem_reg, dvd_reg[WIDTH-1]};
    assign trial_diff = rem_shift - {1'b0, dvs_reg};
    assign q_bit      = ~trial_diff[WIDTH];

    assign quo_final = neg_q_reg ? -dvd_reg : dvd_reg;
    assign rem_final = neg_r_reg ? -rem_reg : rem_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dvd_next    = dvd_reg;
        dvs_next    = dvs_reg;
        rem_next    = rem_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;
        ready_next  = ready_reg;

        unique case (state_reg)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    dvd_next   = op1_abs;
                    dvs_next   = op2_abs;
                    rem_next   = '0;
                    cnt_next   = '0;
                    neg_q_next = op1_neg ^ op2_neg;
                    neg_r_next = op1_neg;
                    state_next = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else begin
                    // Divide-by-zero is defined to yield an all-zero result.
                    dvd_next   = '0;
                    rem_next   = '0;
                    state_next = DivEnd;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else begin
                    rem_next = q_bit ? trial_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    dvd_next = {dvd_reg[WIDTH-2:0], q_bit};
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_next = DivEnd;
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop || annul_i) begin
                    state_next  = DivFree;
                    ready_next  = DivResultNotReady;
                    result_next = '0;
                end else begin
                    ready_next  = DivResultReady;
                    result_next = {rem_final, quo_final};
                end
            end
            default: begin
                state_next = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= DivFree;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
            ready_reg  <= DivResultNotReady;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dvd_reg    <= dvd_next;
            dvs_reg    <= dvs_next;
            rem_reg    <= rem_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
            ready_reg  <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;
    assign busy_o   = (state_reg == DivByZero) || (state_reg == DivOn);
    assign stall_o  = start_i & ~ready_reg & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: an arithmetic reference model checked every
// cycle, plus literal per-transaction expectations.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic           sgn = 1'b0;
    logic [W-1:0]   op1 = '0;
    logic [W-1:0]   op2 = '0;
    logic [2*W-1:0] result;
    logic           ready, busy, stall;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .annul_i  (annul),
        .signed_i (sgn),
        .opdata1_i(op1),
        .opdata2_i(op2),
        .result_o (result),
        .ready_o  (ready),
        .busy_o   (busy),
        .stall_o  (stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: divide magnitudes, then apply the sign rules.
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        ma = (s && a[31]) ? 32'd0 - a : a;
        mb = (s && b[31]) ? 32'd0 - b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (s && (a[31] ^ b[31])) q = 32'd0 - q;
        if (s && a[31])           r = 32'd0 - r;
        return {r, q};
    endfunction

    // Transaction model: age counts edges since accept; ready appears after lat edges.
    bit          m_act = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [63:0] m_res = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (start && !annul) begin
                m_act = 1'b1;
                m_age = 0;
                m_lat = (op2 == '0) ? 2 : W + 1;
                m_res = model_div(op1, op2, sgn);
            end
        end else if (m_age < m_lat - 1) begin
            if (annul) m_act = 1'b0;
            else       m_age++;
        end else begin
            if (!start || annul) m_act = 1'b0;
            else if (m_age < m_lat) m_age++;
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_ready;
        logic [63:0] e_res;
        e_busy  = rst && m_act && (m_age < m_lat - 1);
        e_ready = rst && m_act && (m_age >= m_lat);
        e_res   = e_ready ? m_res : 64'd0;
        check("model_busy",   busy,   e_busy);
        check("model_ready",  ready,  e_ready);
        check("model_result", result, e_res);
        check("model_stall",  stall,  start & ~e_ready & ~annul);
    end

    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp_res, input int exp_lat,
                          input int exp_busy);
        int k, lat, nb;
        bit seen;
        @(posedge clk); #1;
        op1 = a; op2 = b; sgn = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = cyc; nb = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ready) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            if (i == 3) begin
                op1 = $urandom;
                op2 = $urandom;
            end
            @(negedge clk);
        end
        lat = cyc - k;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: ready_o not seen, expected within 100 cycles", name);
        end else begin
            check({name, "_latency"}, lat, exp_lat);
            check({name, "_result"},  result, exp_res);
            check({name, "_busy_cycles"}, nb, exp_busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_ready_drop"},  ready,  64'd0);
        check({name, "_result_drop"}, result, 64'd0);
        $display("txn %s: a=%h b=%h signed=%0d result=%h latency=%0d busy=%0d",
                 name, a, b, s, exp_res, lat, nb);
    endtask

    initial begin
        int rcount;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_ready",  ready,  64'd0);
        check("reset_busy",   busy,   64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        do_div("udiv_100_7",   32'd100,       32'd7,          1'b0, {32'h0000_0002, 32'h0000_000E}, 33, 32);
        do_div("sdiv_m7_2",    32'hFFFF_FFF9, 32'h0000_0002,  1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 32);
        do_div("sdiv_7_m2",    32'h0000_0007, 32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 32);
        do_div("sdiv_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9,  1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 33, 32);
        do_div("udiv_by_zero", 32'd12345,     32'd0,          1'b0, 64'd0, 2, 1);
        do_div("sdiv_by_zero", 32'hFFFF_FFFB, 32'd0,          1'b1, 64'd0, 2, 1);
        do_div("udiv_max_1",   32'hFFFF_FFFF, 32'd1,          1'b0, {32'h0, 32'hFFFF_FFFF}, 33, 32);

        // Annul partway through 0xFFFFFFFF / 3.
        @(posedge clk); #1;
        op1 = 32'hFFFF_FFFF; op2 = 32'd3; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        @(negedge clk);
        check("annul_busy",  busy,  64'd0);
        check("annul_ready", ready, 64'd0);
        rcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) rcount++;
        end
        check("annul_no_ready", rcount, 64'd0);
        $display("txn annul: a=ffffffff b=00000003 annulled after 10 iterations");
        do_div("udiv_after_annul", 32'hFFFF_FFFF, 32'd3, 1'b0, {32'h0, 32'h5555_5555}, 33, 32);

        do_div("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 32);
        do_div("udiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 33, 32);

        // Asynchronous reset during iteration 5.
        @(posedge clk); #1;
        op1 = 32'd100; op2 = 32'd7; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midreset_result", result, 64'd0);
        check("midreset_ready",  ready,  64'd0);
        check("midreset_busy",   busy,   64'd0);
        check("midreset_stall",  stall,  64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        $display("txn reset: async reset asserted at iteration 5 of 100/7");
        do_div("udiv_after_reset", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 33, 32);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
